nios2_debug_ocimem_sequencer: RTL

- Consumes the synchronised JTAG debug-slave outputs (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a) in the clk domain.
- Sequences single-word reads and writes into the on-chip debug RAM (OCI memory), which is shared with the CPU through an external arbiter.
- Returns read data and status (MonDReg, monitor_ready, monitor_error) to the debug slave's TCK-side capture path.
- Directly downstream of the debug slave wrapper, and feeds its MonDReg/monitor_* inputs.

---
 rtl/nios2_debug_pkg.sv | 28 ++
 rtl/nios2_debug_ocimem_timeout.sv | 37 +++
 rtl/nios2_debug_ocimem_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/nios2_debug_pkg.sv
// Shared definitions for the Nios II debug OCI-memory sequencer.
//   - FSM state encoding
//   - bit positions of the fields carried in the 38-bit JTAG data word
//   - helper to detect more than one command pulse in a cycle
package nios2_debug_pkg;

   localparam int JDO_W      = 38;
   localparam int ADDR_LSB   = 17;
   localparam int RDNOW_BIT  = 35;
   localparam int CLRERR_BIT = 36;
   localparam int WDATA_MSB  = 34;
   localparam int WDATA_LSB  = 3;
   localparam int DATA_W     = 32;
   localparam int CNT_W      = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_RDATA = 2'd2,
      ST_DONE  = 2'd3
   } ocimem_state_e;

   // True when at least two of the three command pulses are high together.
   function automatic logic multi_hot3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/nios2_debug_ocimem_timeout.sv
// Grant-wait counter for the OCI-memory sequencer.
//   clk       : system clock
//   reset     : asynchronous active-high reset
//   i_clear   : return the count to zero
//   i_count   : one more cycle spent waiting for a grant
//   o_expire  : this waiting cycle is the TIMEOUT-th one; the request must be dropped
module nios2_debug_ocimem_timeout
   import nios2_debug_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_count,
   output logic o_expire
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_count) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Expire on the cycle whose increment would make the count equal TIMEOUT,
   // so the request is held for exactly TIMEOUT ungranted cycles.
   assign o_expire = i_count && (r_cnt == LP_LAST);

endmodule

// File: rtl/nios2_debug_ocimem_sequencer.sv
// Nios II debug OCI-memory sequencer.
// Turns the synchronised JTAG debug-slave command pulses into single-word
// read/write requests to the shared debug RAM and returns data and status
// (MonDReg, monitor_ready, monitor_error) to the debug slave.
//
// Ports
//   clk, reset                : system clock, asynchronous active-high reset
//   jdo                       : JTAG data word (address, flags, write data)
//   take_action_ocimem_a      : load address; optional read-now / clear-error
//   take_action_ocimem_b      : write jdo data at the current address
//   take_no_action_ocimem_a   : read at the current address
//   ram_gnt, ram_rdata        : arbiter grant, read data (1 cycle after grant)
//   ram_addr, ram_wdata       : RAM address / write data
//   ram_rd, ram_wr            : requests, held until granted
//   MonDReg                   : last read data or last written data
//   monitor_ready             : sequencer idle, MonDReg valid
//   monitor_error             : sticky error (dropped pulse or grant timeout)
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a command pulse
// ST_REQ   | request on the RAM port, waiting for grant or timeout
// ST_RDATA | granted read; RAM returns data this cycle
// ST_DONE  | raise monitor_ready, clear the grant-wait counter
module nios2_debug_ocimem_sequencer
   import nios2_debug_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [JDO_W-1:0]  jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic              ram_gnt,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_rd,
   output logic              ram_wr,
   output logic [DATA_W-1:0] MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error
);

   ocimem_state_e     r_state;
   ocimem_state_e     w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_mondreg;
   logic              r_is_rd;
   logic              r_inc;
   logic              r_ready;
   logic              r_error;

   logic w_idle;
   logic w_any_pulse;
   logic w_accept_a;
   logic w_accept_b;
   logic w_accept_na;
   logic w_start;
   logic w_drop;
   logic w_grant;
   logic w_count;
   logic w_expire;
   logic w_clear_cnt;
   logic w_unused_jdo;

   assign w_idle      = (r_state == ST_IDLE);
   assign w_any_pulse = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

   // Fixed priority a > b > no_action; only honoured from IDLE.
   assign w_accept_a  = w_idle & take_action_ocimem_a;
   assign w_accept_b  = w_idle & take_action_ocimem_b & ~take_action_ocimem_a;
   assign w_accept_na = w_idle & take_no_action_ocimem_a & ~take_action_ocimem_a
                        & ~take_action_ocimem_b;

   // An address-only load does not start an access and keeps monitor_ready high.
   assign w_start = (w_accept_a & jdo[RDNOW_BIT]) | w_accept_b | w_accept_na;

   assign w_drop = (~w_idle & w_any_pulse)
                   | (w_idle & multi_hot3(take_action_ocimem_a, take_action_ocimem_b,
                                          take_no_action_ocimem_a));

   assign w_grant     = (r_state == ST_REQ) & ram_gnt;
   assign w_count     = (r_state == ST_REQ) & ~ram_gnt;
   assign w_clear_cnt = (r_state == ST_DONE);

   nios2_debug_ocimem_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_clear_cnt),
      .i_count  (w_count),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      ram_rd      = 1'b0;
      ram_wr      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            ram_rd = r_is_rd;
            ram_wr = ~r_is_rd;
            if (ram_gnt) begin
               w_state_nxt = r_is_rd ? ST_RDATA : ST_DONE;
            end else if (w_expire) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_RDATA: w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_mondreg <= '0;
         r_is_rd   <= 1'b0;
         r_inc     <= 1'b0;
         r_ready   <= 1'b1;
         r_error   <= 1'b0;
      end else begin
         if (w_accept_a) begin
            r_addr  <= jdo[ADDR_LSB+ADDR_W-1 -: ADDR_W];
            r_is_rd <= 1'b1;
            r_inc   <= 1'b0;
         end
         if (w_accept_b) begin
            r_wdata <= jdo[WDATA_MSB:WDATA_LSB];
            r_is_rd <= 1'b0;
            r_inc   <= 1'b1;
         end
         if (w_accept_na) begin
            r_is_rd <= 1'b1;
            r_inc   <= 1'b1;
         end
         if (w_start) begin
            r_ready <= 1'b0;
         end
         // Address and write readback move only on a granted access, so a
         // timed-out command leaves both untouched.
         if (w_grant) begin
            if (r_inc) begin
               r_addr <= r_addr + ADDR_W'(1);
            end
            if (!r_is_rd) begin
               r_mondreg <= r_wdata;
            end
         end
         if (r_state == ST_RDATA) begin
            r_mondreg <= ram_rdata;
         end
         if (r_state == ST_DONE) begin
            r_ready <= 1'b1;
         end
         // Setting wins over clearing when both happen in the same cycle.
         if (w_accept_a && jdo[CLRERR_BIT]) begin
            r_error <= 1'b0;
         end
         if (w_drop || w_expire) begin
            r_error <= 1'b1;
         end
      end
   end

   assign ram_addr      = r_addr;
   assign ram_wdata     = r_wdata;
   assign MonDReg       = r_mondreg;
   assign monitor_ready = r_ready;
   assign monitor_error = r_error;

   // jdo bits that carry nothing for this block.
   assign w_unused_jdo = &{1'b0, jdo[JDO_W-1], jdo[WDATA_LSB-1:0]};

endmodule
